// File: rtl/disp_pkg.sv
// Shared types and active-low pin encodings for the seven-segment display scheduler.
package disp_pkg;

  typedef enum logic [1:0] {
    SNAP,
    CONV_S,
    CONV_T,
    SCAN
  } state_t;

  typedef logic [1:0] digit_t;

  // Segment codes are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_0   = 4'b1110;
  localparam logic [3:0] AN_1   = 4'b1101;
  localparam logic [3:0] AN_2   = 4'b1011;
  localparam logic [3:0] AN_3   = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic [3:0] an_sel(input digit_t d);
    case (d)
      2'd0:    return AN_0;
      2'd1:    return AN_1;
      2'd2:    return AN_2;
      default: return AN_3;
    endcase
  endfunction

endpackage

// File: rtl/Bin_to_Bcd.sv
// Combinational 6-bit binary to two-digit BCD converter (0..63).
module Bin_to_Bcd (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] base;

  always_comb begin
    tens = '0;
    base = '0;
    for (int unsigned i = 1; i <= 6; i++) begin
      if (bin >= 6'(i * 10)) begin
        tens = 4'(i);
        base = 6'(i * 10);
      end
    end
    ones = 4'(bin - base);
  end

endmodule

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment code; non-decimal codes and blank request go dark.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Frame sequencer: snapshots score/time, converts both through one shared BCD
// converter, then scans the four digits with fully registered pin outputs.
module seg_display_scheduler
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] score,
  input  logic [5:0] time_left,
  input  logic       disp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int unsigned   CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  state_t        state, state_nxt;
  digit_t        dig, dig_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [5:0]    score_q, time_q, conv_in;
  logic [3:0]    conv_tens, conv_ones;
  logic [3:0]    s_ones, s_tens, t_ones, t_tens;
  logic [3:0]    cur_bcd;
  logic          cur_blank;
  logic [6:0]    cur_seg;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt, fd_nxt;

  assign conv_in = (state == CONV_T) ? time_q : score_q;

  Bin_to_Bcd u_bin_to_bcd (
    .bin  (conv_in),
    .tens (conv_tens),
    .ones (conv_ones)
  );

  always_comb begin
    cur_bcd   = s_ones;
    cur_blank = 1'b0;
    case (dig)
      2'd0: cur_bcd = s_ones;
      2'd1: begin
        cur_bcd   = s_tens;
        cur_blank = BLANK_LZ && (s_tens == 4'd0);
      end
      2'd2: cur_bcd = t_ones;
      default: begin
        cur_bcd   = t_tens;
        cur_blank = BLANK_LZ && (t_tens == 4'd0);
      end
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd   (cur_bcd),
    .blank (cur_blank),
    .seg   (cur_seg)
  );

  always_comb begin
    state_nxt = state;
    dig_nxt   = dig;
    cnt_nxt   = cnt;
    fd_nxt    = 1'b0;
    an_nxt    = AN_OFF;
    seg_nxt   = SEG_BLANK;
    dp_nxt    = 1'b1;
    case (state)
      SNAP:   state_nxt = CONV_S;
      CONV_S: state_nxt = CONV_T;
      CONV_T: begin
        state_nxt = SCAN;
        dig_nxt   = '0;
        cnt_nxt   = '0;
      end
      SCAN: begin
        // seg keeps tracking the digit even while disp_en holds the anodes off
        seg_nxt = cur_seg;
        if (disp_en) begin
          an_nxt = an_sel(dig);
          dp_nxt = (dig != 2'd2);
        end
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          dig_nxt = digit_t'(dig + 2'd1);
          if (dig == 2'd3) begin
            state_nxt = SNAP;
            fd_nxt    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = SNAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SNAP;
      dig        <= '0;
      cnt        <= '0;
      score_q    <= '0;
      time_q     <= '0;
      s_ones     <= '0;
      s_tens     <= '0;
      t_ones     <= '0;
      t_tens     <= '0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      dig        <= dig_nxt;
      cnt        <= cnt_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= fd_nxt;
      if (state == SNAP) begin
        score_q <= score;
        time_q  <= time_left;
      end
      if (state == CONV_S) begin
        s_ones <= conv_ones;
        s_tens <= conv_tens;
      end
      if (state == CONV_T) begin
        t_ones <= conv_ones;
        t_tens <= conv_tens;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench: frame-position model checked every cycle plus directed literal checks.
module tb_seg_display_scheduler;

  localparam int RD    = 4;
  localparam int FRAME = 3 + 4 * RD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] score = '0;
  logic [5:0] time_left = '0;
  logic       disp_en = 1'b1;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic       dp1, dp0, fd1, fd0;

  int n_tests = 0;
  int n_fail  = 0;
  int t = 0;
  bit cmp_en = 1'b0;

  seg_display_scheduler #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .time_left(time_left), .disp_en(disp_en),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
  );

  seg_display_scheduler #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .score(score), .time_left(time_left), .disp_en(disp_en),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [6:0] exp_digit(input int v, input bit is_tens, input bit blank_lz);
    if (is_tens && v == 0 && blank_lz) return 7'b1111111;
    return segtab[v];
  endfunction

  // Model: outputs follow purely from the position inside a 19-cycle frame
  int ss, st;
  logic [3:0] m_an = 4'b1111;
  logic [6:0] m_seg1 = 7'h7f, m_seg0 = 7'h7f;
  logic       m_dp = 1'b1, m_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int p, d, v;
    if (!rst_n) begin
      t = 0; m_an = 4'b1111; m_seg1 = 7'h7f; m_seg0 = 7'h7f; m_dp = 1'b1; m_fd = 1'b0;
    end else begin
      t++;
      p = (t - 1) % FRAME;
      if (p == 0) begin
        ss = int'(score);
        st = int'(time_left);
      end
      m_fd = (p == FRAME - 1);
      m_an = 4'b1111; m_dp = 1'b1; m_seg1 = 7'h7f; m_seg0 = 7'h7f;
      if (p >= 3) begin
        d = (p - 3) / RD;
        v = (d == 0) ? ss % 10 : (d == 1) ? ss / 10 : (d == 2) ? st % 10 : st / 10;
        m_seg1 = exp_digit(v, d[0], 1'b1);
        m_seg0 = exp_digit(v, d[0], 1'b0);
        if (disp_en) begin
          m_an = ~(4'b0001 << d);
          m_dp = (d != 2);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %b, expected %b", name, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model an",    7'(an1),  7'(m_an));
      chk("model seg",   seg1,     m_seg1);
      chk("model dp",    7'(dp1),  7'(m_dp));
      chk("model fd",    7'(fd1),  7'(m_fd));
      chk("model an nolz",  7'(an0), 7'(m_an));
      chk("model seg nolz", seg0,    m_seg0);
      chk("model fd nolz",  7'(fd0), 7'(m_fd));
    end
  end

  task automatic at_cycle(input int n);
    int guard = 0;
    while (t < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (t != n) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout waiting for cycle %0d: at %0d, expected %0d", n, t, n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset an",  7'(an1), 7'b0001111);
    chk("reset seg", seg1,    7'b1111111);
    chk("reset dp",  7'(dp1), 7'd1);
    chk("reset fd",  7'(fd1), 7'd0);
    cmp_en = 1'b1;
    rst_n = 1'b1;

    at_cycle(3);  chk("dark c3",   7'(an1), 7'b0001111);
    at_cycle(4);  chk("d0 an",     7'(an1), 7'b0001110);
                  chk("d0 seg",    seg1,    7'b1000000);
    at_cycle(8);  chk("d1 an",     7'(an1), 7'b0001101);
                  chk("d1 blank",  seg1,    7'b1111111);
    at_cycle(12); chk("d2 an",     7'(an1), 7'b0001011);
                  chk("d2 seg",    seg1,    7'b1000000);
                  chk("d2 dp",     7'(dp1), 7'd0);
    at_cycle(16); chk("d3 an",     7'(an1), 7'b0000111);
                  chk("d3 blank",  seg1,    7'b1111111);
    at_cycle(18); chk("fd low c18", 7'(fd1), 7'd0);
    at_cycle(19); chk("fd c19",    7'(fd1), 7'd1);
    score = 6'd47; time_left = 6'd59;

    at_cycle(23); chk("47 ones", seg1, 7'b1111000);
    at_cycle(27); chk("47 tens", seg1, 7'b0011001);
    at_cycle(31); chk("59 ones", seg1, 7'b0010000);
    at_cycle(35); chk("59 tens", seg1, 7'b0010010);
    at_cycle(36); score = 6'd12;

    at_cycle(42); chk("12 ones", seg1, 7'b0100100);
    at_cycle(46); chk("12 tens", seg1, 7'b1111001);
    score = 6'd63;
    at_cycle(49); chk("12 tens held", seg1, 7'b1111001);
    at_cycle(61); chk("63 ones", seg1, 7'b0110000);
    at_cycle(65); chk("63 tens", seg1, 7'b0000010);

    at_cycle(82); disp_en = 1'b0;
    at_cycle(85); chk("en off an",  7'(an1), 7'b0001111);
                  chk("en off seg", seg1,    7'b0000010);
    at_cycle(92); disp_en = 1'b1;
    at_cycle(93); chk("en back an", 7'(an1), 7'b0000111);
    at_cycle(95); chk("fd c95",  7'(fd1), 7'd1);
    at_cycle(114); chk("fd c114", 7'(fd1), 7'd1);

    at_cycle(127); chk("pre-reset an", 7'(an1), 7'b0001011);
    #2 rst_n = 1'b0;
    #1;
    chk("async an",  7'(an1), 7'b0001111);
    chk("async seg", seg1,    7'b1111111);
    chk("async dp",  7'(dp1), 7'd1);
    chk("async fd",  7'(fd1), 7'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    at_cycle(3); chk("restart dark", 7'(an1), 7'b0001111);
    at_cycle(4); chk("restart an",   7'(an1), 7'b0001110);
                 chk("restart seg",  seg1,    7'b0110000);

    at_cycle(19); score = 6'd5;
    at_cycle(27); chk("nolz tens",  seg0,    7'b1000000);
                  chk("nolz an",    7'(an0), 7'b0001101);
                  chk("lz tens",    seg1,    7'b1111111);
    at_cycle(45);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
